// File: rtl/ttl_bcd_counter_n_if.sv
// Signal bundle for ttl_bcd_counter_n: load/enable/direction controls in, count and terminal flags out.
// Bundle only: no timing or flow control of its own.
interface ttl_bcd_counter_n_if #(
  parameter int DIGITS = 4
);
  logic                PE_n;
  logic                CEP;
  logic                CET;
  logic                U_D;
  logic                CLR_OVF;
  logic [4*DIGITS-1:0] P;
  logic [4*DIGITS-1:0] Q;
  logic [DIGITS-1:0]   DTC;
  logic                TC;
  logic                OVF;

  modport master (
    output PE_n, CEP, CET, U_D, CLR_OVF, P,
    input  Q, DTC, TC, OVF
  );

  modport slave (
    input  PE_n, CEP, CET, U_D, CLR_OVF, P,
    output Q, DTC, TC, OVF
  );
endinterface

// File: rtl/ttl_bcd_counter_n.sv
// DIGITS-wide synchronous mod-MODULUS counter; Q/OVF one cycle after sampled inputs, DTC/TC combinational.
// No backpressure: CEP/CET gate counting. Define TTL_CNT_DOWN_EN to honour U_D (down counting).
module ttl_bcd_counter_n #(
  parameter int DIGITS  = 4,
  parameter int MODULUS = 10
) (
  input  logic               clk,
  input  logic               MR,
  ttl_bcd_counter_n_if.slave bus
);
  localparam logic [3:0] TERM_UP = 4'(MODULUS - 1);
  localparam logic [4:0] MOD5    = 5'(MODULUS);

  logic [4*DIGITS-1:0] q;
  logic [4*DIGITS-1:0] q_step;
  logic [DIGITS-1:0]   dtc;
  logic [DIGITS:0]     carry;
  logic                all_term;
  logic                step_en;
  logic                ovf;

  // Illegal digits (>= MODULUS) recover to 0 going up.
  function automatic logic [3:0] step_up(input logic [3:0] d);
    if (({1'b0, d} >= MOD5) || (d == TERM_UP)) return 4'd0;
    return d + 4'd1;
  endfunction

`ifdef TTL_CNT_DOWN_EN
  logic up;
  assign up = bus.U_D;

  function automatic logic [3:0] step_down(input logic [3:0] d);
    if (({1'b0, d} >= MOD5) || (d == 4'd0)) return TERM_UP;
    return d - 4'd1;
  endfunction
`else
  logic unused_ud;
  assign unused_ud = bus.U_D;
`endif

  // carry[i] is the lookahead "all lower digits terminal" term, so every digit steps on the same edge.
  always_comb begin
    q_step   = q;
    dtc      = '0;
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
`ifdef TTL_CNT_DOWN_EN
      dtc[i] = up ? (q[4*i +: 4] == TERM_UP) : (q[4*i +: 4] == 4'd0);
      if (carry[i]) q_step[4*i +: 4] = up ? step_up(q[4*i +: 4]) : step_down(q[4*i +: 4]);
`else
      dtc[i] = (q[4*i +: 4] == TERM_UP);
      if (carry[i]) q_step[4*i +: 4] = step_up(q[4*i +: 4]);
`endif
      carry[i+1] = carry[i] & dtc[i];
    end
  end

  assign all_term = carry[DIGITS];
  assign step_en  = bus.PE_n & bus.CEP & bus.CET;

  always_ff @(posedge clk) begin
    if (MR) begin
      q   <= '0;
      ovf <= 1'b0;
    end else begin
      if (!bus.PE_n) begin
        q <= bus.P;
      end else if (step_en) begin
        q <= q_step;
      end
      // A wrap on the same edge as a clear request keeps the flag set.
      if (step_en && all_term) begin
        ovf <= 1'b1;
      end else if (bus.CLR_OVF) begin
        ovf <= 1'b0;
      end
    end
  end

  assign bus.Q   = q;
  assign bus.DTC = dtc;
  assign bus.TC  = bus.CET & all_term;
  assign bus.OVF = ovf;
endmodule

// File: tb/tb_ttl_bcd_counter_n.sv
// Bench for ttl_bcd_counter_n: a 4-digit BCD counter and a 2-digit mod-6 counter checked against a digit-list model.
module tb_ttl_bcd_counter_n;
  logic clk = 1'b0;
  logic mr;
  always #5 clk = ~clk;

  ttl_bcd_counter_n_if #(.DIGITS(4)) a_if();
  ttl_bcd_counter_n_if #(.DIGITS(2)) b_if();

  ttl_bcd_counter_n #(.DIGITS(4), .MODULUS(10)) dut_a (.clk(clk), .MR(mr), .bus(a_if));
  ttl_bcd_counter_n #(.DIGITS(2), .MODULUS(6))  dut_b (.clk(clk), .MR(mr), .bus(b_if));

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          started  = 1'b0;
  logic [31:0] ma, mb;
  logic        oa, ob;
  bit          wa, wb;

  function automatic bit dir_up(input logic ud);
`ifdef TTL_CNT_DOWN_EN
    return ud;
`else
    return ud | 1'b1;
`endif
  endfunction

  // Odometer-style step: walk from the low digit, rolling terminal digits and stopping at the first that simply moves.
  function automatic logic [31:0] m_step(input logic [31:0] v, input int n, input int md, input bit up);
    logic [31:0] r = v;
    for (int i = 0; i < n; i++) begin
      int d = int'(v[4*i +: 4]);
      if (d >= md) begin
        r[4*i +: 4] = up ? 4'd0 : 4'(md - 1);
        break;
      end
      if (up) begin
        if (d == md - 1) r[4*i +: 4] = 4'd0;
        else begin r[4*i +: 4] = 4'(d + 1); break; end
      end else begin
        if (d == 0) r[4*i +: 4] = 4'(md - 1);
        else begin r[4*i +: 4] = 4'(d - 1); break; end
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] m_dtc(input logic [31:0] v, input int n, input int md, input bit up);
    logic [7:0] r = '0;
    for (int i = 0; i < n; i++)
      r[i] = (int'(v[4*i +: 4]) == (up ? md - 1 : 0));
    return r;
  endfunction

  function automatic bit m_all(input logic [31:0] v, input int n, input int md, input bit up);
    logic [7:0] mask = 8'((1 << n) - 1);
    return (m_dtc(v, n, md, up) & mask) == mask;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (mr) begin
      ma = '0; oa = 1'b0; mb = '0; ob = 1'b0;
    end else begin
      wa = a_if.PE_n && a_if.CEP && a_if.CET && m_all(ma, 4, 10, dir_up(a_if.U_D));
      if (!a_if.PE_n) ma = 32'(a_if.P);
      else if (a_if.CEP && a_if.CET) ma = m_step(ma, 4, 10, dir_up(a_if.U_D));
      if (wa) oa = 1'b1; else if (a_if.CLR_OVF) oa = 1'b0;

      wb = b_if.PE_n && b_if.CEP && b_if.CET && m_all(mb, 2, 6, dir_up(b_if.U_D));
      if (!b_if.PE_n) mb = 32'(b_if.P);
      else if (b_if.CEP && b_if.CET) mb = m_step(mb, 2, 6, dir_up(b_if.U_D));
      if (wb) ob = 1'b1; else if (b_if.CLR_OVF) ob = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("a_q",   32'(a_if.Q),   ma);
      check("a_dtc", 32'(a_if.DTC), 32'(m_dtc(ma, 4, 10, dir_up(a_if.U_D))));
      check("a_tc",  32'(a_if.TC),  32'(a_if.CET & m_all(ma, 4, 10, dir_up(a_if.U_D))));
      check("a_ovf", 32'(a_if.OVF), 32'(oa));
      check("b_q",   32'(b_if.Q),   mb);
      check("b_dtc", 32'(b_if.DTC), 32'(m_dtc(mb, 2, 6, dir_up(b_if.U_D))));
      check("b_tc",  32'(b_if.TC),  32'(b_if.CET & m_all(mb, 2, 6, dir_up(b_if.U_D))));
      check("b_ovf", 32'(b_if.OVF), 32'(ob));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [15:0] v);
    a_if.PE_n = 1'b0; a_if.P = v;
    tick();
    a_if.PE_n = 1'b1;
  endtask

  task automatic load_b(input logic [7:0] v);
    b_if.PE_n = 1'b0; b_if.P = v;
    tick();
    b_if.PE_n = 1'b1;
  endtask

  initial begin
    mr = 1'b1;
    a_if.PE_n = 1'b1; a_if.CEP = 1'b0; a_if.CET = 1'b0; a_if.U_D = 1'b1; a_if.CLR_OVF = 1'b0; a_if.P = '0;
    b_if.PE_n = 1'b1; b_if.CEP = 1'b0; b_if.CET = 1'b0; b_if.U_D = 1'b1; b_if.CLR_OVF = 1'b0; b_if.P = '0;
    tick();
    started = 1'b1;
    mr = 1'b0;
    check("lit_reset_q",   32'(a_if.Q),   32'h0);
    check("lit_reset_ovf", 32'(a_if.OVF), 32'h0);
    check("lit_reset_dtc", 32'(a_if.DTC), 32'h0);
    a_if.CEP = 1'b1; a_if.CET = 1'b1;
    #1 check("lit_reset_tc", 32'(a_if.TC), 32'h0);

    // Full BCD count and wrap
    repeat (99) tick();
    check("lit_q_99", 32'(a_if.Q), 32'h0099);
    repeat (9900) tick();
    check("lit_q_9999", 32'(a_if.Q),   32'h9999);
    check("lit_tc_9999", 32'(a_if.TC), 32'h1);
    tick();
    check("lit_wrap_q",   32'(a_if.Q),   32'h0000);
    check("lit_wrap_ovf", 32'(a_if.OVF), 32'h1);

    // Enable gating
    load_a(16'h0009);
    a_if.CEP = 1'b0;
    tick();
    check("lit_cep0_hold", 32'(a_if.Q),   32'h0009);
    check("lit_cep0_tc",   32'(a_if.TC),  32'h0);
    check("lit_dtc_0009",  32'(a_if.DTC), 32'h1);
    a_if.CEP = 1'b1; a_if.CET = 1'b0;
    tick();
    check("lit_cet0_hold", 32'(a_if.Q), 32'h0009);
    load_a(16'h9999);
    check("lit_cet0_tc_9999", 32'(a_if.TC), 32'h0);
    tick();
    check("lit_cet0_hold_9999", 32'(a_if.Q),   32'h9999);
    check("lit_load_keeps_ovf", 32'(a_if.OVF), 32'h1);
    load_a(16'h0009);
    a_if.CET = 1'b1;
    tick();
    check("lit_0009_to_0010", 32'(a_if.Q), 32'h0010);

    // OVF clear on a plain step, then clear losing to a wrap
    a_if.CLR_OVF = 1'b1;
    tick();
    a_if.CLR_OVF = 1'b0;
    check("lit_clr_ovf", 32'(a_if.OVF), 32'h0);
    load_a(16'h9999);
    a_if.CLR_OVF = 1'b1;
    tick();
    a_if.CLR_OVF = 1'b0;
    check("lit_set_wins", 32'(a_if.OVF), 32'h1);

    // Illegal digit recovery without carry
    load_a(16'h00BC);
    check("lit_load_bc", 32'(a_if.Q), 32'h00BC);
    tick();
    check("lit_illegal_step", 32'(a_if.Q), 32'h00B0);
    repeat (20) tick();

    // Master clear beats a same-edge load
    mr = 1'b1; a_if.PE_n = 1'b0; a_if.P = 16'h1234;
    tick();
    mr = 1'b0; a_if.PE_n = 1'b1;
    check("lit_mr_beats_load", 32'(a_if.Q),   32'h0000);
    check("lit_mr_ovf",        32'(a_if.OVF), 32'h0);

`ifdef TTL_CNT_DOWN_EN
    a_if.U_D = 1'b0;
    #1;
    check("lit_down_dtc_0", 32'(a_if.DTC), 32'hF);
    check("lit_down_tc_0",  32'(a_if.TC),  32'h1);
    load_a(16'h0100);
    tick();
    check("lit_down_0100", 32'(a_if.Q), 32'h0099);
    load_a(16'h0000);
    a_if.CET = 1'b0;
    #1 check("lit_down_tc_cet0", 32'(a_if.TC), 32'h0);
    a_if.CET = 1'b1;
    tick();
    check("lit_down_wrap_q",   32'(a_if.Q),   32'h9999);
    check("lit_down_wrap_ovf", 32'(a_if.OVF), 32'h1);
    load_a(16'h00B3);
    repeat (15) tick();
    a_if.U_D = 1'b1;
`endif
    a_if.CEP = 1'b0;

    // Mod-36 pair
    load_b(8'h05);
    check("lit_b_dtc_05", 32'(b_if.DTC), 32'h1);
    b_if.CEP = 1'b1; b_if.CET = 1'b1;
    tick();
    check("lit_b_05_10", 32'(b_if.Q), 32'h10);
    load_b(8'h55);
    check("lit_b_tc_55", 32'(b_if.TC), 32'h1);
    tick();
    check("lit_b_wrap_q",   32'(b_if.Q),   32'h00);
    check("lit_b_wrap_ovf", 32'(b_if.OVF), 32'h1);
    repeat (35) tick();
    check("lit_b_35", 32'(b_if.Q), 32'h55);
    tick();
    check("lit_b_36", 32'(b_if.Q), 32'h00);
    repeat (4) tick();

    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
